// File: rtl/button_debouncer.sv
// Debounces a synchronised push-button level using en-strobe ticks and
// emits registered press, release and long-press pulses.
module button_debouncer #(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter int DCNT_W         = $clog2(DEBOUNCE_TICKS + 1),
    parameter int LCNT_W         = $clog2(LONG_TICKS + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic long_press
);

    // state     | meaning
    // IDLE_LOW  | settled low, out=0
    // WAIT_HIGH | input high, counting ticks before accepting the press
    // HIGH      | settled high, out=1, long-press timer running
    // WAIT_LOW  | input low, counting ticks before accepting the release
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG_TICKS - 1);
    localparam logic [LCNT_W-1:0] LCNT_MAX  = LCNT_W'(LONG_TICKS);

    state_t            state, state_next;
    logic [DCNT_W-1:0] dcnt, dcnt_next;
    logic [LCNT_W-1:0] lcnt, lcnt_next;
    logic              out_next, rise_next, fall_next, long_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE_LOW;
            dcnt       <= '0;
            lcnt       <= '0;
            out        <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            long_press <= 1'b0;
        end else begin
            state      <= state_next;
            dcnt       <= dcnt_next;
            lcnt       <= lcnt_next;
            out        <= out_next;
            rise       <= rise_next;
            fall       <= fall_next;
            long_press <= long_next;
        end
    end

    always_comb begin
        state_next = state;
        dcnt_next  = dcnt;
        lcnt_next  = lcnt;
        case (state)
            IDLE_LOW: begin
                if (in) begin
                    state_next = WAIT_HIGH;
                    dcnt_next  = '0;
                end
            end
            WAIT_HIGH: begin
                if (!in) begin
                    state_next = IDLE_LOW;
                    dcnt_next  = '0;
                end else if (en) begin
                    if (dcnt == DCNT_LAST) begin
                        state_next = HIGH;
                        dcnt_next  = '0;
                        lcnt_next  = '0;
                    end else begin
                        dcnt_next = dcnt + DCNT_W'(1);
                    end
                end
            end
            HIGH: begin
                if (!in) begin
                    state_next = WAIT_LOW;
                    dcnt_next  = '0;
                end
                // long-press timer keeps running on the clk the release starts
                if (en && (lcnt < LCNT_MAX)) begin
                    lcnt_next = lcnt + LCNT_W'(1);
                end
            end
            WAIT_LOW: begin
                if (in) begin
                    state_next = HIGH;
                    dcnt_next  = '0;
                end else if (en) begin
                    if (dcnt == DCNT_LAST) begin
                        state_next = IDLE_LOW;
                        dcnt_next  = '0;
                        lcnt_next  = '0;
                    end else begin
                        dcnt_next = dcnt + DCNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE_LOW;
                dcnt_next  = '0;
                lcnt_next  = '0;
            end
        endcase
    end

    always_comb begin
        out_next  = (state_next == HIGH) || (state_next == WAIT_LOW);
        rise_next = (state == WAIT_HIGH) && (state_next == HIGH);
        fall_next = (state == WAIT_LOW) && (state_next == IDLE_LOW);
        long_next = (state == HIGH) && en && (lcnt == LCNT_LAST);
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random bouncing input,
// every cycle compared against a level/mismatch-run reference model.
module tb_button_debouncer;

    localparam int DEB  = 4;
    localparam int LONG = 10;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic in;
    logic out, rise, fall, long_press;

    int vectors     = 0;
    int miscompares = 0;

    // reference model: accepted level, whether the input currently disagrees
    // with it, en ticks counted during that disagreement, ticks spent settled high
    logic m_lvl  = 1'b0;
    logic m_wait = 1'b0;
    int   m_cnt  = 0;
    int   m_ltk  = 0;
    logic e_rise = 1'b0;
    logic e_fall = 1'b0;
    logic e_long = 1'b0;

    int rise_cnt = 0;
    int fall_cnt = 0;
    int long_cnt = 0;

    button_debouncer #(
        .DEBOUNCE_TICKS(DEB),
        .LONG_TICKS    (LONG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in        (in),
        .out       (out),
        .rise      (rise),
        .fall      (fall),
        .long_press(long_press)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic in_v, input logic en_v, input logic rst_v);
        e_rise = 1'b0;
        e_fall = 1'b0;
        e_long = 1'b0;
        if (rst_v) begin
            m_lvl  = 1'b0;
            m_wait = 1'b0;
            m_cnt  = 0;
            m_ltk  = 0;
        end else begin
            if (m_lvl && !m_wait && en_v) begin
                m_ltk++;
                if (m_ltk == LONG) e_long = 1'b1;
            end
            if (in_v == m_lvl) begin
                m_wait = 1'b0;
                m_cnt  = 0;
            end else if (!m_wait) begin
                m_wait = 1'b1;
                m_cnt  = 0;
            end else if (en_v) begin
                m_cnt++;
                if (m_cnt == DEB) begin
                    m_lvl  = ~m_lvl;
                    m_wait = 1'b0;
                    m_cnt  = 0;
                    m_ltk  = 0;
                    if (m_lvl) e_rise = 1'b1;
                    else       e_fall = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic in_v, input logic en_v, input logic rst_v);
        in    = in_v;
        en    = en_v;
        reset = rst_v;
        @(posedge clk);
        model_update(in_v, en_v, rst_v);
        #1;
        check("out", 32'(out), 32'(m_lvl));
        check("rise", 32'(rise), 32'(e_rise));
        check("fall", 32'(fall), 32'(e_fall));
        check("long_press", 32'(long_press), 32'(e_long));
        if (rise) rise_cnt++;
        if (fall) fall_cnt++;
        if (long_press) long_cnt++;
    endtask

    // n en ticks at one every 4 clk, the tick on the last clk of each group
    task automatic hold(input logic in_v, input int n);
        for (int k = 0; k < 4 * n; k++) step(in_v, (k % 4) == 3, 1'b0);
    endtask

    task automatic clear_counts();
        rise_cnt = 0;
        fall_cnt = 0;
        long_cnt = 0;
    endtask

    initial begin
        logic lv;
        int   len;
        int   mode;

        in    = 1'b1;
        en    = 1'b0;
        reset = 1'b1;

        // reset held 3 clk with the button pressed, then normal acceptance
        for (int k = 0; k < 3; k++) step(1'b1, k == 1, 1'b1);
        clear_counts();
        hold(1'b1, 5);
        check("reset_then_press_rise", 32'(rise_cnt), 32'd1);
        check("reset_then_press_out", 32'(out), 32'd1);
        hold(1'b0, 5);
        check("first_release_fall", 32'(fall_cnt), 32'd1);

        // bounce rejection then a clean press
        clear_counts();
        hold(1'b1, 2);
        hold(1'b0, 1);
        hold(1'b1, 3);
        hold(1'b0, 1);
        check("bounce_no_rise", 32'(rise_cnt), 32'd0);
        check("bounce_out_low", 32'(out), 32'd0);
        hold(1'b1, 4);
        check("clean_press_rise", 32'(rise_cnt), 32'd1);

        // long press, then a release bounce that must not count
        clear_counts();
        hold(1'b1, 20);
        check("long_once", 32'(long_cnt), 32'd1);
        hold(1'b0, 2);
        hold(1'b1, 2);
        check("release_bounce_no_fall", 32'(fall_cnt), 32'd0);
        check("release_bounce_no_relong", 32'(long_cnt), 32'd1);
        hold(1'b0, 5);
        check("release_fall", 32'(fall_cnt), 32'd1);

        // a fresh press re-arms the long-press timer
        clear_counts();
        hold(1'b1, 16);
        check("second_press_rise", 32'(rise_cnt), 32'd1);
        check("second_press_long", 32'(long_cnt), 32'd1);
        hold(1'b0, 5);

        // reset in the middle of a pending press discards the progress
        clear_counts();
        hold(1'b1, 3);
        step(1'b1, 1'b0, 1'b1);
        hold(1'b1, 3);
        check("mid_reset_no_rise", 32'(rise_cnt), 32'd0);
        hold(1'b1, 1);
        check("mid_reset_full_count", 32'(rise_cnt), 32'd1);
        hold(1'b0, 5);

        // no en: bounces tracked but nothing ever committed
        clear_counts();
        for (int k = 0; k < 60; k++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("no_en_no_rise", 32'(rise_cnt), 32'd0);

        // random bouncing input, mixed en densities, rare resets
        for (int r = 0; r < 220; r++) begin
            lv   = 1'($urandom_range(0, 1));
            len  = $urandom_range(1, 30);
            mode = $urandom_range(0, 3);
            for (int k = 0; k < len; k++) begin
                step(lv, (mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0),
                     $urandom_range(0, 299) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Sits directly downstream of the 3-stage input synchroniser on each push-button channel; consumes its synchronised level.
- Produces a glitch-free debounced level plus single-cycle press, release and long-press pulses for UI/control logic.
- Timing is counted in enable ticks from a shared strobe generator (typically 1 kHz), so thresholds are in ms-scale ticks, not clocks.

Parameters:
- DEBOUNCE_TICKS, 20, consecutive en ticks the input must hold a new level before it is accepted. Must be >= 1.
- LONG_TICKS, 1000, en ticks the debounced level must stay high, counted from entry to HIGH, before long_press fires. Must be >= 1.
- DCNT_W, $clog2(DEBOUNCE_TICKS+1), debounce counter width (derived).
- LCNT_W, $clog2(LONG_TICKS+1), long-press counter width (derived).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  timing tick strobe, one clk wide
- in  in  1  synchronised raw button level (from synchroniser)
- out  out  1  debounced level (registered)
- rise  out  1  one-clk pulse on accepted 0->1 transition
- fall  out  1  one-clk pulse on accepted 1->0 transition
- long_press  out  1  one-clk pulse, once per press, when held LONG_TICKS ticks

Behaviour:
- Reset: state=IDLE_LOW, dcnt=0, lcnt=0, out=0, rise=0, fall=0, long_press=0. Reset has priority over all other inputs, including mid-operation (a pending transition is discarded).
- All outputs are registered; rise/fall/long_press default to 0 every clk unless set below.
- FSM, evaluated every clk (the in comparisons run every clk; counters advance only on en):
  - IDLE_LOW: out=0. If in=1 -> WAIT_HIGH, dcnt=0.
  - WAIT_HIGH: If in=0 -> IDLE_LOW, dcnt=0 (bounce rejected, no pulse). Else if en: if dcnt==DEBOUNCE_TICKS-1 -> HIGH, out<=1, rise<=1, lcnt=0, dcnt=0; else dcnt++.
  - HIGH: out=1. If in=0 -> WAIT_LOW, dcnt=0. If en and lcnt<LONG_TICKS: lcnt++; long_press<=1 on the edge where lcnt goes LONG_TICKS-1 -> LONG_TICKS. lcnt saturates at LONG_TICKS (no repeat). Both actions can occur on the same clk.
  - WAIT_LOW: out stays 1, lcnt holds. If in=1 -> HIGH, dcnt=0 (release bounce rejected, lcnt not cleared). Else if en: if dcnt==DEBOUNCE_TICKS-1 -> IDLE_LOW, out<=0, fall<=1, lcnt=0, dcnt=0; else dcnt++.
- Latency: out/rise update on the clk edge that samples the DEBOUNCE_TICKS-th en while in is stable; visible the following cycle. An en on the same clk in which in first changes (IDLE_LOW/HIGH) is not counted.
- en held low: FSM still tracks in (rejects bounces) but never commits a transition.
- en held high continuously: thresholds become clock counts.
- rise and fall are never asserted in the same cycle; long_press never asserts while out=0.

Test Plan:
- Reset/idle: DEBOUNCE_TICKS=4, LONG_TICKS=10, en every 4 clk; assert reset 3 clk with in=1 -> out=rise=fall=long_press=0 during and 1 clk after reset, then normal acceptance after 4 en ticks.
- Clean press: in 0->1, held -> rise is a single 1-clk pulse on the edge sampling the 4th en after the change; out=1 from the next cycle; no fall.
- Bounce rejection: in toggles 1 for 2 en ticks, 0, 1 for 3 ticks, 0 -> out stays 0, rise never asserts; then hold 1 for 4 ticks -> exactly one rise.
- Long press: hold in=1 for 20 ticks -> long_press pulses exactly once, at the 10th en after entering HIGH; release bounce (0 for 2 ticks, back to 1) -> no fall, no second long_press.
- Release: from HIGH drop in to 0 for 4 ticks -> fall 1-clk pulse, out=0; new press afterwards -> long_press fires again after 10 ticks.
- Reset mid-operation: in=1 with dcnt=3 in WAIT_HIGH, pulse reset -> no rise; returns to IDLE_LOW, with a full 4 ticks needed afterwards.
